// File: rtl/sound_pkg.sv
// Shared constants for the sound channel controllers: register offsets,
// read-back OR masks and frame-sequencer step constants.
package sound_pkg;

  localparam logic [1:0] NR41_OFS = 2'd0;
  localparam logic [1:0] NR42_OFS = 2'd1;
  localparam logic [1:0] NR43_OFS = 2'd2;
  localparam logic [1:0] NR44_OFS = 2'd3;

  localparam logic [7:0] NR41_RD_OR = 8'hFF;
  localparam logic [7:0] NR44_RD_OR = 8'hBF;

  localparam logic [7:0] LEN_STEPS = 8'b01010101;
  localparam logic [2:0] ENV_STEP  = 3'd7;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_NR41,
    SEL_NR42,
    SEL_NR43,
    SEL_NR44
  } reg_sel_e;

  // ofs is the bus address minus the channel base address
  function automatic reg_sel_e decode_sel(input logic [15:0] ofs);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (ofs[15:2] == 14'd0) begin
      case (ofs[1:0])
        NR41_OFS: sel = SEL_NR41;
        NR42_OFS: sel = SEL_NR42;
        NR43_OFS: sel = SEL_NR43;
        NR44_OFS: sel = SEL_NR44;
        default:  sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sound_frame_seq.sv
// Frame sequencer: 3-bit step counter advanced by the 512 Hz tick, producing
// registered one-clock length (256 Hz) and envelope (64 Hz) strobes.
module sound_frame_seq
  import sound_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick_512,
  output logic clk_length_ctr,
  output logic clk_vol_env
);

  logic [2:0] step_q, step_d;
  logic       len_q, len_d;
  logic       env_q, env_d;

  // Strobes are decoded from the step being left, so the first tick after
  // power-on (leaving step 0) yields a length strobe.
  always_comb begin
    step_d = step_q;
    len_d  = 1'b0;
    env_d  = 1'b0;
    if (!en) begin
      step_d = 3'd0;
    end else if (tick_512) begin
      step_d = step_q + 3'd1;
      len_d  = LEN_STEPS[step_q];
      env_d  = (step_q == ENV_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q <= 3'd0;
      len_q  <= 1'b0;
      env_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      len_q  <= len_d;
      env_q  <= env_d;
    end
  end

  assign clk_length_ctr = len_q;
  assign clk_vol_env    = env_q;

endmodule

// File: rtl/sound_noise_ctrl.sv
// Noise channel controller: NR41..NR44 register file, trigger hold and frame
// sequencer. Define SOUND_NOISE_READBACK_EN to build the register read mux.
module sound_noise_ctrl
  import sound_pkg::*;
#(
  parameter int unsigned START_HOLD = 4,
  parameter logic [15:0] BASE_ADDR  = 16'hFF20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  input  logic        sound_en,
  input  logic        tick_512,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [3:0]  shift_clock_freq,
  output logic        counter_width,
  output logic [2:0]  freq_dividing_ratio,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_vol_env,
  output logic        dac_on
);

  localparam logic [3:0] HOLD_INIT = 4'(START_HOLD);

  logic [15:0] ofs;
  reg_sel_e    sel;
  logic        wr_en;
  logic        trig;

  logic [5:0] nr41_q, nr41_d;
  logic [7:0] nr42_q, nr42_d;
  logic [7:0] nr43_q, nr43_d;
  logic       single_q, single_d;
  logic [3:0] hold_q, hold_d;

  assign ofs   = a - BASE_ADDR;
  assign sel   = decode_sel(ofs);
  assign wr_en = wr && sound_en;

  // The trigger checks the DAC enable as it will be after this write.
  always_comb begin
    nr41_d   = nr41_q;
    nr42_d   = nr42_q;
    nr43_d   = nr43_q;
    single_d = single_q;
    if (wr_en) begin
      case (sel)
        SEL_NR41: nr41_d   = din[5:0];
        SEL_NR42: nr42_d   = din;
        SEL_NR43: nr43_d   = din;
        SEL_NR44: single_d = din[6];
        default:  ;
      endcase
    end
    trig = wr_en && (sel == SEL_NR44) && din[7] && (nr42_d[7:3] != 5'd0);
    if (trig) begin
      hold_d = HOLD_INIT;
    end else if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
    end else begin
      hold_d = 4'd0;
    end
    if (!sound_en) begin
      nr41_d   = 6'd0;
      nr42_d   = 8'd0;
      nr43_d   = 8'd0;
      single_d = 1'b0;
      hold_d   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      nr41_q   <= 6'd0;
      nr42_q   <= 8'd0;
      nr43_q   <= 8'd0;
      single_q <= 1'b0;
      hold_q   <= 4'd0;
    end else begin
      nr41_q   <= nr41_d;
      nr42_q   <= nr42_d;
      nr43_q   <= nr43_d;
      single_q <= single_d;
      hold_q   <= hold_d;
    end
  end

`ifdef SOUND_NOISE_READBACK_EN
  logic [7:0] dout_q, dout_d;

  // Reads use the registered values, so a same-cycle write is not visible.
  always_comb begin
    dout_d = dout_q;
    if (rd) begin
      case (sel)
        SEL_NR41: dout_d = NR41_RD_OR;
        SEL_NR42: dout_d = nr42_q;
        SEL_NR43: dout_d = nr43_q;
        SEL_NR44: dout_d = {1'b0, single_q, 6'd0} | NR44_RD_OR;
        default:  dout_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q <= 8'hFF;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  logic unused_rd;
  assign unused_rd = rd;
  assign dout      = 8'hFF;
`endif

  sound_frame_seq u_frame_seq (
    .clk            (clk),
    .rst            (rst),
    .en             (sound_en),
    .tick_512       (tick_512),
    .clk_length_ctr (clk_length_ctr),
    .clk_vol_env    (clk_vol_env)
  );

  assign length              = nr41_q;
  assign initial_volume      = nr42_q[7:4];
  assign envelope_increasing = nr42_q[3];
  assign num_envelope_sweeps = nr42_q[2:0];
  assign shift_clock_freq    = nr43_q[7:4];
  assign counter_width       = nr43_q[3];
  assign freq_dividing_ratio = nr43_q[2:0];
  assign single              = single_q;
  assign start               = (hold_q != 4'd0);
  assign dac_on              = (nr42_q[7:3] != 5'd0);

endmodule

// File: tb/tb_sound_noise_ctrl.sv
// Bench for sound_noise_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-count based model of the channel.
module tb_sound_noise_ctrl;

  localparam int          HOLD = 4;
  localparam logic [15:0] BASE = 16'hFF20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        sound_en = 1'b1;
  logic        tick_512 = 1'b0;
  logic [7:0]  dout;
  logic [5:0]  length;
  logic [3:0]  initial_volume;
  logic        envelope_increasing;
  logic [2:0]  num_envelope_sweeps;
  logic [3:0]  shift_clock_freq;
  logic        counter_width;
  logic [2:0]  freq_dividing_ratio;
  logic        single;
  logic        start;
  logic        clk_length_ctr;
  logic        clk_vol_env;
  logic        dac_on;

  sound_noise_ctrl #(.START_HOLD(HOLD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .wr(wr), .rd(rd), .dout(dout),
    .sound_en(sound_en), .tick_512(tick_512), .length(length),
    .initial_volume(initial_volume), .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps), .shift_clock_freq(shift_clock_freq),
    .counter_width(counter_width), .freq_dividing_ratio(freq_dividing_ratio),
    .single(single), .start(start), .clk_length_ctr(clk_length_ctr),
    .clk_vol_env(clk_vol_env), .dac_on(dac_on)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Model state: stored register bytes, the last edge on which start must
  // still be high, and the number of ticks seen since power-on.
  logic [5:0] m41;
  logic [7:0] m42, m43;
  logic       msingle;
  logic [7:0] e_dout;
  logic       e_len, e_env;
  int         edge_n = 0;
  int         start_last = -1;
  int         ticks = 0;

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    int o;
    o = int'(addr) - int'(BASE);
`ifdef SOUND_NOISE_READBACK_EN
    case (o)
      0: return 8'hFF;
      1: return m42;
      2: return m43;
      3: return {1'b1, msingle, 6'h3F};
      default: return 8'hFF;
    endcase
`else
    return (o == 1000) ? 8'h00 : 8'hFF;
`endif
  endfunction

  always @(posedge clk) begin
    int o, s;
    edge_n++;
    if (!rst) begin
      m41 = 0; m42 = 0; m43 = 0; msingle = 0;
      start_last = -1; ticks = 0; e_len = 0; e_env = 0; e_dout = 8'hFF;
    end else begin
      if (rd) e_dout = model_read(a);
      e_len = 0; e_env = 0;
      if (!sound_en) begin
        m41 = 0; m42 = 0; m43 = 0; msingle = 0; start_last = -1; ticks = 0;
      end else begin
        if (tick_512) begin
          ticks++;
          s = (ticks - 1) % 8;
          e_len = (s % 2 == 0);
          e_env = (s == 7);
        end
        if (wr) begin
          o = int'(a) - int'(BASE);
          case (o)
            0: m41 = din[5:0];
            1: m42 = din;
            2: m43 = din;
            3: begin
              msingle = din[6];
              if (din[7] && m42[7:3] != 0) start_last = edge_n + HOLD - 1;
            end
            default: ;
          endcase
        end
      end
    end
    #1;
    chk("length", 16'(length), 16'(m41));
    chk("initial_volume", 16'(initial_volume), 16'(m42[7:4]));
    chk("envelope_increasing", 16'(envelope_increasing), 16'(m42[3]));
    chk("num_envelope_sweeps", 16'(num_envelope_sweeps), 16'(m42[2:0]));
    chk("shift_clock_freq", 16'(shift_clock_freq), 16'(m43[7:4]));
    chk("counter_width", 16'(counter_width), 16'(m43[3]));
    chk("freq_dividing_ratio", 16'(freq_dividing_ratio), 16'(m43[2:0]));
    chk("single", 16'(single), 16'(msingle));
    chk("dac_on", 16'(dac_on), 16'(m42[7:3] != 0));
    chk("start", 16'(start), 16'(edge_n <= start_last));
    chk("clk_length_ctr", 16'(clk_length_ctr), 16'(e_len));
    chk("clk_vol_env", 16'(clk_vol_env), 16'(e_env));
    chk("dout", 16'(dout), 16'(e_dout));
  end

  task automatic cyc(input logic w, input logic r, input logic [15:0] addr,
                     input logic [7:0] d, input logic t);
    wr = w; rd = r; a = addr; din = d; tick_512 = t;
    @(posedge clk);
    #2;
    wr = 0; rd = 0; tick_512 = 0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  int cnt, len_cnt, env_cnt, env_first, env_second;

  initial begin
    // Reset held with write traffic
    rst = 0; sound_en = 1;
    cyc(1'b1, 1'b0, BASE + 16'd2, 8'h5B, 1'b0);
    cyc(1'b1, 1'b0, BASE + 16'd1, 8'hF3, 1'b0);
    cyc(1'b1, 1'b0, BASE + 16'd3, 8'hC0, 1'b1);
    chk("rst_shift_clock_freq", 16'(shift_clock_freq), 16'd0);
    chk("rst_dout", 16'(dout), 16'h00FF);
    chk("rst_start", 16'(start), 16'd0);
    rst = 1;
    idle();

    // NR43 write and read back
    cyc(1'b1, 1'b0, BASE + 16'd2, 8'h5B, 1'b0);
    chk("lit_shift_clock_freq", 16'(shift_clock_freq), 16'd5);
    chk("lit_counter_width", 16'(counter_width), 16'd1);
    chk("lit_freq_dividing_ratio", 16'(freq_dividing_ratio), 16'd3);
    cyc(1'b0, 1'b1, BASE + 16'd2, 8'h00, 1'b0);
`ifdef SOUND_NOISE_READBACK_EN
    chk("lit_read_nr43", 16'(dout), 16'h005B);
`else
    chk("lit_read_nr43", 16'(dout), 16'h00FF);
`endif

    // Trigger: start high for exactly HOLD cycles
    cyc(1'b1, 1'b0, BASE + 16'd1, 8'hF3, 1'b0);
    cyc(1'b1, 1'b0, BASE + 16'd3, 8'hC0, 1'b0);
    chk("lit_single", 16'(single), 16'd1);
    chk("lit_dac_on", 16'(dac_on), 16'd1);
    cnt = int'(start);
    for (int i = 0; i < 8; i++) begin idle(); cnt += int'(start); end
    chk("lit_start_len", 16'(cnt), 16'd4);

    // Retrigger during the second start cycle
    cyc(1'b1, 1'b0, BASE + 16'd3, 8'h80, 1'b0);
    cnt = int'(start);
    idle(); cnt += int'(start);
    cyc(1'b1, 1'b0, BASE + 16'd3, 8'h80, 1'b0); cnt += int'(start);
    for (int i = 0; i < 10; i++) begin idle(); cnt += int'(start); end
    chk("lit_retrigger_len", 16'(cnt), 16'd6);

    // DAC off suppresses the trigger
    cyc(1'b1, 1'b0, BASE + 16'd1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, BASE + 16'd3, 8'h80, 1'b0);
    cnt = int'(start);
    for (int i = 0; i < 6; i++) begin idle(); cnt += int'(start); end
    chk("lit_dac_off_start", 16'(cnt), 16'd0);

    // Frame sequencer from a fresh power-on
    sound_en = 0; idle(); sound_en = 1; idle();
    len_cnt = 0; env_cnt = 0; env_first = 0; env_second = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      len_cnt += int'(clk_length_ctr);
      if (clk_vol_env) begin
        env_cnt++;
        if (env_first == 0) env_first = i; else env_second = i;
      end
      idle();
      len_cnt += int'(clk_length_ctr);
      env_cnt += int'(clk_vol_env);
    end
    chk("lit_len_strobes", 16'(len_cnt), 16'd8);
    chk("lit_env_strobes", 16'(env_cnt), 16'd2);
    chk("lit_env_first", 16'(env_first), 16'd8);
    chk("lit_env_second", 16'(env_second), 16'd16);

    // Power-off clears state and blocks writes and ticks
    cyc(1'b1, 1'b0, BASE + 16'd1, 8'hF3, 1'b0);
    cyc(1'b1, 1'b0, BASE + 16'd2, 8'h5B, 1'b0);
    sound_en = 0;
    idle();
    chk("lit_off_volume", 16'(initial_volume), 16'd0);
    chk("lit_off_shift", 16'(shift_clock_freq), 16'd0);
    chk("lit_off_dac", 16'(dac_on), 16'd0);
    cyc(1'b1, 1'b0, BASE + 16'd3, 8'h80, 1'b0);
    chk("lit_off_start", 16'(start), 16'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
      cnt += int'(clk_length_ctr) + int'(clk_vol_env);
    end
    chk("lit_off_strobes", 16'(cnt), 16'd0);
    sound_en = 1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] addr;
      rst = ($urandom_range(0, 199) != 0);
      if (sound_en) begin
        if ($urandom_range(0, 149) == 0) sound_en = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        sound_en = 1;
      end
      if ($urandom_range(0, 7) == 0) addr = 16'($urandom);
      else addr = BASE + 16'($urandom_range(0, 3));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, addr,
          8'($urandom), $urandom_range(0, 7) == 0);
    end
    rst = 1; sound_en = 1;
    idle(); idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sound_noise_ctrl.md
Name: sound_noise_ctrl

Overview:
- CPU-side controller and sequencer for the noise sound channel.
- Decodes bus writes to NR41–NR44 (FF20–FF23) and holds the channel configuration fields.
- Generates the trigger (start) pulse and a frame sequencer that produces the length-counter and volume-envelope clock strobes from a 512 Hz tick.
- Sits between the CPU bus / sound master control and the noise datapath; one instance per noise channel.

Parameters:
- START_HOLD, 4, number of clk cycles the start output stays high after a trigger write (1..15).
- BASE_ADDR, 16'hFF20, address of NR41; NR42..NR44 follow at +1..+3.

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous active-low reset
- a  in  16  CPU address
- din  in  8  CPU write data
- wr  in  1  write strobe, one clk cycle per access
- rd  in  1  read strobe
- dout  out  8  read data
- sound_en  in  1  NR52 master power bit
- tick_512  in  1  one-clk pulse at 512 Hz (from DIV)
- length  out  6  NR41[5:0]
- initial_volume  out  4  NR42[7:4]
- envelope_increasing  out  1  NR42[3]
- num_envelope_sweeps  out  3  NR42[2:0]
- shift_clock_freq  out  4  NR43[7:4]
- counter_width  out  1  NR43[3]
- freq_dividing_ratio  out  3  NR43[2:0]
- single  out  1  NR44[6]
- start  out  1  trigger, high for START_HOLD cycles
- clk_length_ctr  out  1  256 Hz strobe, high one clk
- clk_vol_env  out  1  64 Hz strobe, high one clk
- dac_on  out  1  NR42[7:3] != 0

Behaviour:
- Reset (rst==0 at posedge clk): all config outputs 0, start 0, strobes 0, step counter 0, hold counter 0, dout 8'hFF.
- Reset is synchronous only; no asynchronous path.
- Writes:
  - On wr with a in BASE_ADDR..+3 and sound_en==1, the addressed register updates at the next clk edge.
  - Outputs reflect the new value 1 cycle after wr.
  - NR44 write stores bit 6 only; bit 7 is a trigger and is not stored.
- Power-off:
  - While sound_en==0, writes are ignored and all registers are held at 0.
  - start, strobes and the step counter are forced to 0.
  - The sound_en 1->0 edge clears everything within 1 cycle.
- Trigger:
  - NR44 write with din[7]==1 and sound_en==1 loads the hold counter with START_HOLD.
  - start = (hold counter != 0); start rises 1 cycle after wr.
  - Counter decrements each clk.
  - A retrigger while start is high reloads to START_HOLD; start stays high with no gap.
  - A trigger while dac_on==0 (including a same-cycle NR42 write making it 0) is suppressed.
  - A trigger in the same write as NR44 bit 6 uses the new single value.
- Frame sequencer:
  - 3-bit step counter increments on tick_512 and wraps 7->0.
  - On the tick that leaves step s:
    - clk_length_ctr pulses when s is in {0,2,4,6}.
    - clk_vol_env pulses when s==7.
  - Each pulse is registered: 1 clk high, 1 cycle after tick_512.
  - tick_512 ignored while sound_en==0.
  - The first tick after power-on leaves step 0, so it produces a length strobe.
- Reads:
  - dout is registered; valid 1 cycle after rd.
  - NR41 reads 8'hFF (write-only).
  - NR42 reads its stored value.
  - NR43 reads its stored value.
  - NR44 reads {1'b1, single, 6'h3F}.
  - Any other address reads 8'hFF.
- Simultaneous wr and rd to the same register: the read returns the pre-write value.

Optional Feature:
- SOUND_NOISE_READBACK_EN
  - Defined: the read mux is as above.
  - Undefined: dout is constant 8'hFF and rd is ignored, saving the mux for builds without readback.

Decomposition:
- Shared package sound_pkg:
  - NR41..NR44 address offsets.
  - Read-OR masks (NR41 8'hFF, NR44 8'hBF).
  - Frame-sequencer step constants: LEN_STEPS mask 8'b01010101, ENV_STEP 3'd7.
- One natural sub-module: sound_frame_seq (step counter plus the two strobes). It is reusable by the square and wave channels and instantiated here.

Test Plan:
- Reset: hold rst=0 for 3 cycles with wr pulsing -> all outputs 0, dout 8'hFF, no register changes.
- Config write, sound_en=1:
  - Write FF22=8'h5B -> shift_clock_freq=5, counter_width=1, freq_dividing_ratio=3, 1 cycle after wr.
  - Read FF22 -> 8'h5B.
- Trigger:
  - Write FF21=8'hF3, then FF23=8'hC0 -> single=1, dac_on=1, start high exactly 4 cycles (START_HOLD=4).
  - Retrigger on cycle 2 -> start high for 6 cycles total.
- DAC-off suppression: write FF21=8'h00, then FF23=8'h80 -> start stays 0.
- Frame sequencer: 16 tick_512 pulses -> 8 clk_length_ctr and 2 clk_vol_env strobes, each 1 clk wide, vol_env on the 8th and 16th tick.
- Power-off: after config, drop sound_en -> registers 0 next cycle; a write FF23=8'h80 is ignored; ticks produce no strobes.
